// File: rtl/mem_access_ctrl_if.sv
// Data-side sram-like bus between the MEM-stage access controller and memory.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, one registered bus request
// per access, pipeline stall until the data phase completes, raw read capture.
module mem_access_ctrl (
  input  logic                clk,
  input  logic                rst,
  input  logic                memenM,
  input  logic [5:0]          opM,
  input  logic [31:0]         addrM,
  input  logic [31:0]         writedataM,
  input  logic                flushM,
  input  logic                stallotherM,
  output logic                stallmemM,
  output logic                adelM,
  output logic                adesM,
  output logic [31:0]         readdataM,
  mem_access_ctrl_if.master   bus
);

  localparam logic [5:0] op_LB  = 6'b100000;
  localparam logic [5:0] op_LH  = 6'b100001;
  localparam logic [5:0] op_LW  = 6'b100011;
  localparam logic [5:0] op_LBU = 6'b100100;
  localparam logic [5:0] op_LHU = 6'b100101;
  localparam logic [5:0] op_SB  = 6'b101000;
  localparam logic [5:0] op_SH  = 6'b101001;
  localparam logic [5:0] op_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state;
  logic        cancel;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size_c;
  logic        misaligned;
  logic        go;
  logic [31:0] wdata_rep;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_c   = 2'd0;
    case (opM)
      op_LB, op_LBU: begin is_load  = 1'b1; size_c = 2'd0; end
      op_LH, op_LHU: begin is_load  = 1'b1; size_c = 2'd1; end
      op_LW:         begin is_load  = 1'b1; size_c = 2'd2; end
      op_SB:         begin is_store = 1'b1; size_c = 2'd0; end
      op_SH:         begin is_store = 1'b1; size_c = 2'd1; end
      op_SW:         begin is_store = 1'b1; size_c = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = (is_load | is_store) &
                 (((size_c == 2'd1) & addrM[0]) | ((size_c == 2'd2) & (addrM[1:0] != 2'b00)));
    adelM      = memenM & is_load  & misaligned;
    adesM      = memenM & is_store & misaligned;
    go         = memenM & (is_load | is_store) & ~misaligned & ~flushM;
    stallmemM  = ((state == IDLE) & go) | (state == ADDR) | (state == DATA);
  end

  always_comb begin
    case (size_c)
      2'd0:    wdata_rep = {4{writedataM[7:0]}};
      2'd1:    wdata_rep = {2{writedataM[15:0]}};
      default: wdata_rep = writedataM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cancel         <= 1'b0;
      bus.data_req   <= 1'b0;
      bus.data_wr    <= 1'b0;
      bus.data_size  <= 2'd0;
      bus.data_addr  <= '0;
      bus.data_wdata <= '0;
      readdataM      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (go) begin
            bus.data_req   <= 1'b1;
            bus.data_wr    <= is_store;
            bus.data_size  <= size_c;
            bus.data_addr  <= addrM;
            bus.data_wdata <= wdata_rep;
            state          <= ADDR;
          end
        end
        ADDR: begin
          if (flushM) cancel <= 1'b1;
          // Request is held through a cancel; the bus must see the address accepted.
          if (bus.data_addr_ok) begin
            bus.data_req <= 1'b0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (flushM) cancel <= 1'b1;
          // A flush arriving with data_ok counts as a cancel in that same cycle.
          if (bus.data_data_ok) begin
            if (cancel | flushM) begin
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              if (!bus.data_wr) readdataM <= bus.data_rdata;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!stallotherM || flushM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage controller that sequences every load and store from the five-stage pipeline onto the sram-like data bus. It checks alignment, drives one registered bus request per access, and stalls the pipeline until the data phase completes. It then holds the raw 32-bit read word stable until the pipeline advances; the WB-stage load extractor performs byte and halfword selection and extension.

## Interface
- No parameters. Opcodes come from `defines.vh` (`op_LB`, `op_LBU`, `op_LH`, `op_LHU`, `op_LW`, `op_SB`, `op_SH`, `op_SW`).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- memenM  in  1  MEM-stage instruction is a valid load/store
- opM  in  6  MEM-stage opcode
- addrM  in  32  effective address (ALU result)
- writedataM  in  32  store source register value
- flushM  in  1  cancel MEM-stage instruction (exception/eret)
- stallotherM  in  1  pipeline held by another source this cycle
- stallmemM  out  1  stall request to hazard unit
- adelM  out  1  load address error (combinational)
- adesM  out  1  store address error (combinational)
- readdataM  out  32  captured raw read word
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  32  read data, valid with data_data_ok

## Operation
- Misalignment rules: halfword with addrM[0]=1, or word with addrM[1:0]≠0.
  - Loads assert adelM; stores assert adesM.
  - Both are combinational and gated by memenM.
  - A misaligned access issues no request and causes no stall.
- Access `go` = memenM & aligned & !flushM.
- Store data replication: SB gives {4{writedataM[7:0]}}; SH gives {2{writedataM[15:0]}}; SW passes writedataM unchanged.
- FSM states IDLE, ADDR, DATA, DONE.
  - IDLE: on go, load bus registers (data_wr, data_size, data_addr=addrM, data_wdata) and move to ADDR.
  - ADDR: data_req=1. Bus registers are held stable. On data_addr_ok, move to DATA.
  - DATA: on data_data_ok, capture data_rdata into readdataM (loads only) and move to DONE, or to IDLE if cancelled.
  - DONE: if !stallotherM or flushM, move to IDLE.
- Cancel bit:
  - Set by flushM while in ADDR or DATA; cleared on return to IDLE.
  - data_req is never withdrawn before data_addr_ok, even when cancelled.
  - A cancelled transaction completes on the bus and its read data is discarded.
- stallmemM = (IDLE & go) | ADDR | DATA.
  - stallmemM is 0 in DONE.
  - stallmemM stays 1 while a cancelled transaction is outstanding.
- Only one outstanding transaction at a time.

## Timing
- Reset (synchronous): state=IDLE, cancel=0, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, readdataM=0. rst mid-transaction returns to IDLE next edge and drops data_req; the bus side is reset together.
- Best case, addr_ok in the first ADDR cycle and data_ok the following cycle:
  - cycle 0: IDLE, stall
  - cycle 1: ADDR, req
  - cycle 2: DATA, data_ok
  - cycle 3: DONE, no stall; the pipeline advances.
- data_data_ok is never expected in the same cycle as data_addr_ok. data_data_ok received outside DATA is ignored.
- readdataM holds from the DONE entry edge until the next capture.
- data_rdata is only sampled in DATA with data_data_ok=1.

## Test plan
- LW addr 0x00000104: addr_ok on first req cycle, data_ok next cycle with rdata 0xDEADBEEF -> stallmemM high exactly 3 cycles, then readdataM=0xDEADBEEF, data_size=2, data_wr=0.
- SB addr 0x00000103, writedataM=0x123456A5 -> data_wr=1, data_size=0, data_wdata=0xA5A5A5A5, data_addr=0x00000103; SH addr 0x102, writedataM=0x0000BEEF -> data_wdata=0xBEEFBEEF, data_size=1.
- LH addr 0x00000101 -> adelM=1, no data_req, stallmemM=0; SW addr 0x00000102 -> adesM=1, no req.
- addr_ok delayed 4 cycles -> data_req, data_addr and data_wdata stable throughout; stallotherM=1 for 2 cycles in DONE -> stay DONE, readdataM stable, stallmemM=0.
- flushM during ADDR -> req held until addr_ok, stall held until data_ok, readdataM unchanged (prior value), then IDLE.
- rst asserted in DATA -> next edge all outputs at reset values, a subsequent LW completes normally.
